// File: rtl/phase_step_decoder.sv
// Receive-side decoder for a 4-phase one-hot ring: synchronizes and debounces the phase
// lines, then tracks steps (direction, wrapping position) and flags illegal or skipped phases.
module phase_step_decoder #(
  parameter int STABLE_CYC = 2,
  parameter int POS_W      = 8
) (
  input  logic             C_IN,
  input  logic             RST_N,
  input  logic             Phase1,
  input  logic             Phase2,
  input  logic             Phase3,
  input  logic             Phase4,
  input  logic             CLR_ERR,
  output logic             STEP,
  output logic             DIR,
  output logic [POS_W-1:0] POS,
  output logic [1:0]       PH_IDX,
  output logic             LOCKED,
  output logic             ERR
);

  typedef enum logic [1:0] {
    S_SEARCH = 2'd0,
    S_TRACK  = 2'd1,
    S_FAULT  = 2'd2
  } state_t;

  localparam int                RUN_W   = $clog2(STABLE_CYC + 2);
  localparam logic [RUN_W-1:0]  RUN_ACC = RUN_W'(STABLE_CYC);
  localparam logic [RUN_W-1:0]  RUN_MAX = RUN_W'(STABLE_CYC + 1);

  logic [3:0]       phase_v;
  logic [3:0]       sync1_q, sync2_q;
  logic [RUN_W-1:0] run_q, run_d;
  state_t           state_q, state_d;
  logic             step_q, step_d;
  logic             dir_q, dir_d;
  logic [POS_W-1:0] pos_q, pos_d;
  logic [1:0]       ph_idx_q, ph_idx_d;
  logic             err_q, err_d;

  logic             accept;
  logic             cand_valid;
  logic             cand_illegal;
  logic [1:0]       cand_idx;
  logic [1:0]       delta;

  assign phase_v = {Phase4, Phase3, Phase2, Phase1};

  // Run length of the synchronized pattern saturates one past the threshold, so the
  // acceptance compare below is true for exactly one cycle per stable pattern.
  always_comb begin
    if (sync1_q == sync2_q) begin
      run_d = (run_q == RUN_MAX) ? run_q : run_q + RUN_W'(1);
    end else begin
      run_d = RUN_W'(1);
    end
  end

  assign accept = (run_q == RUN_ACC);

  always_comb begin
    cand_valid   = 1'b1;
    cand_illegal = 1'b0;
    cand_idx     = 2'd0;
    unique case (sync2_q)
      4'b0001: cand_idx = 2'd0;
      4'b0010: cand_idx = 2'd1;
      4'b0100: cand_idx = 2'd2;
      4'b1000: cand_idx = 2'd3;
      4'b0000: cand_valid = 1'b0;
      default: begin
        cand_valid   = 1'b0;
        cand_illegal = 1'b1;
      end
    endcase
  end

  // Modulo-4 distance from the current phase: 1 = forward, 3 = reverse, 2 = skipped phase.
  assign delta = cand_idx - ph_idx_q;

  // NOTE: every combinational output gets a default first so no path leaves it unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    state_d  = state_q;
    step_d   = 1'b0;
    dir_d    = dir_q;
    pos_d    = pos_q;
    ph_idx_d = ph_idx_q;
    err_d    = err_q;
    unique case (state_q)
      S_SEARCH: begin
        if (accept && cand_valid) begin
          state_d  = S_TRACK;
          ph_idx_d = cand_idx;
        end else if (accept && cand_illegal) begin
          state_d = S_FAULT;
          err_d   = 1'b1;
        end
      end
      S_TRACK: begin
        if (accept && cand_illegal) begin
          state_d = S_FAULT;
          err_d   = 1'b1;
        end else if (accept && cand_valid) begin
          unique case (delta)
            2'd1: begin
              step_d   = 1'b1;
              dir_d    = 1'b1;
              pos_d    = pos_q + POS_W'(1);
              ph_idx_d = cand_idx;
            end
            2'd3: begin
              step_d   = 1'b1;
              dir_d    = 1'b0;
              pos_d    = pos_q - POS_W'(1);
              ph_idx_d = cand_idx;
            end
            2'd2: begin
              state_d = S_FAULT;
              err_d   = 1'b1;
            end
            default: ;
          endcase
        end
      end
      S_FAULT: begin
        if (CLR_ERR) begin
          state_d = S_SEARCH;
          err_d   = 1'b0;
        end
      end
      default: state_d = S_SEARCH;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together
  // from the values present before the edge.
  always_ff @(posedge C_IN) begin
    if (!RST_N) begin
      sync1_q  <= 4'b0000;
      sync2_q  <= 4'b0000;
      run_q    <= '0;
      state_q  <= S_SEARCH;
      step_q   <= 1'b0;
      dir_q    <= 1'b0;
      pos_q    <= '0;
      ph_idx_q <= 2'd0;
      err_q    <= 1'b0;
    end else begin
      sync1_q  <= phase_v;
      sync2_q  <= sync1_q;
      run_q    <= run_d;
      state_q  <= state_d;
      step_q   <= step_d;
      dir_q    <= dir_d;
      pos_q    <= pos_d;
      ph_idx_q <= ph_idx_d;
      err_q    <= err_d;
    end
  end

  assign STEP   = step_q;
  assign DIR    = dir_q;
  assign POS    = pos_q;
  assign PH_IDX = ph_idx_q;
  assign LOCKED = (state_q == S_TRACK);
  assign ERR    = err_q;

endmodule

// File: tb/tb_phase_step_decoder.sv
// Bench for phase_step_decoder: directed scenarios plus a randomized run, all checked
// against a history-window reference model of the acceptance and stepping rules.
module tb_phase_step_decoder;

  localparam int STABLE_CYC = 2;
  localparam int POS_W      = 8;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             p1, p2, p3, p4;
  logic             clr_err;
  logic             step, dir, locked, err;
  logic [POS_W-1:0] pos;
  logic [1:0]       ph_idx;

  always #5 clk = ~clk;

  phase_step_decoder #(.STABLE_CYC(STABLE_CYC), .POS_W(POS_W)) dut (
    .C_IN(clk), .RST_N(rst_n),
    .Phase1(p1), .Phase2(p2), .Phase3(p3), .Phase4(p4),
    .CLR_ERR(clr_err),
    .STEP(step), .DIR(dir), .POS(pos), .PH_IDX(ph_idx), .LOCKED(locked), .ERR(err)
  );

  typedef enum {M_SEARCH, M_TRACK, M_FAULT} mstate_t;

  // Reference model: hist holds the raw phase vector sampled at every edge.
  logic [3:0]       hist[$];
  mstate_t          m_state;
  bit               m_step, m_dir, m_err;
  logic [POS_W-1:0] m_pos;
  int               m_idx;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int change_edge = 0;
  int cyc_mismatch = 0;
  int dut_steps = 0;
  int mdl_steps = 0;
  int lat_min, lat_max;
  logic [3:0] cur_v = 4'b0000;

  task automatic model_reset();
    hist.delete();
    for (int i = 0; i < STABLE_CYC + 3; i++) hist.push_back(4'b0000);
    m_state = M_SEARCH;
    m_step  = 1'b0;
    m_dir   = 1'b0;
    m_err   = 1'b0;
    m_pos   = '0;
    m_idx   = 0;
  endtask

  // A pattern is accepted at the edge where it has been the synchronized value for exactly
  // STABLE_CYC samples; the synchronized value lags the raw samples by two edges.
  function automatic bit accepted(output logic [3:0] c);
    int n = hist.size();
    c = hist[n-2];
    for (int i = 0; i < STABLE_CYC; i++)
      if (hist[n-2-i] != c) return 1'b0;
    if (hist[n-2-STABLE_CYC] == c) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_edge(input logic [3:0] v, input bit rst, input bit clr);
    logic [3:0] c;
    bit acc;
    int idx, d;
    if (!rst) begin
      model_reset();
      return;
    end
    acc    = accepted(c);
    m_step = 1'b0;
    if (m_state == M_FAULT) begin
      if (clr) begin
        m_state = M_SEARCH;
        m_err   = 1'b0;
      end
    end else if (acc && c != 4'b0000) begin
      idx = -1;
      for (int i = 0; i < 4; i++) if (c == (4'b0001 << i)) idx = i;
      if (idx < 0) begin
        m_state = M_FAULT;
        m_err   = 1'b1;
      end else if (m_state == M_SEARCH) begin
        m_state = M_TRACK;
        m_idx   = idx;
      end else begin
        d = (idx - m_idx + 4) % 4;
        if (d == 1) begin
          m_step = 1'b1; m_dir = 1'b1; m_pos = m_pos + 1; m_idx = idx;
        end else if (d == 3) begin
          m_step = 1'b1; m_dir = 1'b0; m_pos = m_pos - 1; m_idx = idx;
        end else if (d == 2) begin
          m_state = M_FAULT;
          m_err   = 1'b1;
        end
      end
    end
    hist.push_back(v);
    if (hist.size() > 32) void'(hist.pop_front());
  endtask

  task automatic cycle(input logic [3:0] v, input bit rst, input bit clr);
    int lat;
    @(negedge clk);
    {p4, p3, p2, p1} = v;
    rst_n   = rst;
    clr_err = clr;
    if (v != cur_v) change_edge = cyc + 1;
    cur_v = v;
    @(posedge clk);
    cyc++;
    model_edge(v, rst, clr);
    #1;
    if (step === 1'b1) begin
      dut_steps++;
      lat = cyc - change_edge;
      if (lat < lat_min) lat_min = lat;
      if (lat > lat_max) lat_max = lat;
    end
    if (m_step) mdl_steps++;
    if ({step, dir, pos, ph_idx, locked, err} !==
        {m_step, m_dir, m_pos, m_idx[1:0], (m_state == M_TRACK), m_err})
      cyc_mismatch++;
  endtask

  task automatic drive(input logic [3:0] v, input int n);
    for (int i = 0; i < n; i++) cycle(v, 1'b1, 1'b0);
  endtask

  task automatic clear_stats();
    dut_steps = 0;
    mdl_steps = 0;
    lat_min   = 1000;
    lat_max   = -1;
  endtask

  task automatic test_reset();
    cycle(4'b0000, 1'b0, 1'b0);
    cycle(4'b0001, 1'b0, 1'b0);
    checks++;
    if ({step, dir, pos, ph_idx, locked, err} !== 14'h0) begin
      errors++;
      $display("FAIL reset_outputs: got %b expected all zero", {step, dir, pos, ph_idx, locked, err});
    end
  endtask

  task automatic test_forward();
    clear_stats();
    drive(4'b0001, 4);
    checks++;
    if (locked !== 1'b1 || dut_steps != 0) begin
      errors++;
      $display("FAIL fwd_lock: got locked=%b steps=%0d expected locked=1 steps=0", locked, dut_steps);
    end
    drive(4'b0010, 4); drive(4'b0100, 4); drive(4'b1000, 4); drive(4'b0001, 4);
    checks++;
    if (dut_steps != 4 || dir !== 1'b1 || pos !== 8'd4 || ph_idx !== 2'd0) begin
      errors++;
      $display("FAIL fwd_ring: got steps=%0d dir=%b pos=%0h idx=%0d expected 4 1 04 0",
               dut_steps, dir, pos, ph_idx);
    end
    checks++;
    if (lat_min != 1 + STABLE_CYC || lat_max != 1 + STABLE_CYC) begin
      errors++;
      $display("FAIL fwd_latency: got min=%0d max=%0d expected %0d", lat_min, lat_max, 1 + STABLE_CYC);
    end
  endtask

  task automatic test_reverse();
    clear_stats();
    drive(4'b1000, 4); drive(4'b0100, 4); drive(4'b0010, 4);
    drive(4'b0001, 4); drive(4'b1000, 4); drive(4'b0100, 4);
    checks++;
    if (dut_steps != 6 || dir !== 1'b0 || pos !== 8'hFE || ph_idx !== 2'd2) begin
      errors++;
      $display("FAIL rev_ring: got steps=%0d dir=%b pos=%0h idx=%0d expected 6 0 fe 2",
               dut_steps, dir, pos, ph_idx);
    end
  endtask

  task automatic test_glitch();
    drive(4'b0010, 6);
    clear_stats();
    drive(4'b0110, 1);
    drive(4'b0010, 8);
    checks++;
    if (dut_steps != 0 || pos !== 8'hFD || ph_idx !== 2'd1 || locked !== 1'b1) begin
      errors++;
      $display("FAIL glitch: got steps=%0d pos=%0h idx=%0d locked=%b expected 0 fd 1 1",
               dut_steps, pos, ph_idx, locked);
    end
  endtask

  task automatic test_skip_fault();
    drive(4'b0001, 6);
    drive(4'b0100, 4);
    checks++;
    if (err !== 1'b1 || locked !== 1'b0 || pos !== 8'hFC) begin
      errors++;
      $display("FAIL skip_fault: got err=%b locked=%b pos=%0h expected 1 0 fc", err, locked, pos);
    end
    clear_stats();
    drive(4'b1000, 6); drive(4'b0001, 6);
    checks++;
    if (dut_steps != 0 || pos !== 8'hFC || err !== 1'b1 || ph_idx !== 2'd0) begin
      errors++;
      $display("FAIL fault_frozen: got steps=%0d pos=%0h err=%b idx=%0d expected 0 fc 1 0",
               dut_steps, pos, err, ph_idx);
    end
    cycle(4'b0001, 1'b1, 1'b1);
    drive(4'b0001, 2);
    checks++;
    if (err !== 1'b0 || locked !== 1'b0) begin
      errors++;
      $display("FAIL clr_err: got err=%b locked=%b expected 0 0", err, locked);
    end
    drive(4'b0010, 6);
    checks++;
    if (locked !== 1'b1 || dut_steps != 0 || ph_idx !== 2'd1 || pos !== 8'hFC) begin
      errors++;
      $display("FAIL relock: got locked=%b steps=%0d idx=%0d pos=%0h expected 1 0 1 fc",
               locked, dut_steps, ph_idx, pos);
    end
  endtask

  task automatic test_illegal_gap();
    drive(4'b0011, 4);
    checks++;
    if (err !== 1'b1 || locked !== 1'b0) begin
      errors++;
      $display("FAIL illegal: got err=%b locked=%b expected 1 0", err, locked);
    end
    drive(4'b0000, 10);
    checks++;
    if (err !== 1'b1 || locked !== 1'b0 || pos !== 8'hFC) begin
      errors++;
      $display("FAIL gap_fault: got err=%b locked=%b pos=%0h expected 1 0 fc", err, locked, pos);
    end
    cycle(4'b0000, 1'b1, 1'b1);
    drive(4'b0010, 6);
    clear_stats();
    drive(4'b0000, 10);
    checks++;
    if (locked !== 1'b1 || dut_steps != 0 || ph_idx !== 2'd1 || err !== 1'b0) begin
      errors++;
      $display("FAIL gap_track: got locked=%b steps=%0d idx=%0d err=%b expected 1 0 1 0",
               locked, dut_steps, ph_idx, err);
    end
  endtask

  task automatic test_clr_collision();
    for (int i = 0; i < 1 + STABLE_CYC; i++) cycle(4'b1100, 1'b1, 1'b0);
    cycle(4'b1100, 1'b1, 1'b1);
    drive(4'b1100, 2);
    checks++;
    if (err !== 1'b1 || locked !== 1'b0) begin
      errors++;
      $display("FAIL clr_collision: got err=%b locked=%b expected 1 0", err, locked);
    end
    cycle(4'b0000, 1'b1, 1'b1);
  endtask

  task automatic test_reset_mid();
    cycle(4'b0000, 1'b0, 1'b0);
    drive(4'b0001, 4);
    drive(4'b0010, 4); drive(4'b0100, 4); drive(4'b1000, 4);
    drive(4'b0001, 4); drive(4'b0010, 4);
    checks++;
    if (pos !== 8'h05) begin
      errors++;
      $display("FAIL pre_reset_pos: got %0h expected 05", pos);
    end
    cycle(4'b0010, 1'b0, 1'b0);
    checks++;
    if ({step, dir, pos, ph_idx, locked, err} !== 14'h0) begin
      errors++;
      $display("FAIL mid_reset: got %b expected all zero", {step, dir, pos, ph_idx, locked, err});
    end
    clear_stats();
    drive(4'b0100, 6);
    checks++;
    if (locked !== 1'b1 || dut_steps != 0 || ph_idx !== 2'd2 || pos !== 8'h00) begin
      errors++;
      $display("FAIL post_reset_lock: got locked=%b steps=%0d idx=%0d pos=%0h expected 1 0 2 00",
               locked, dut_steps, ph_idx, pos);
    end
  endtask

  task automatic test_random();
    int idx = 0;
    int r;
    logic [3:0] v;
    clear_stats();
    for (int s = 0; s < 300; s++) begin
      r = $urandom_range(0, 99);
      if (r < 70) begin
        idx = (idx + $urandom_range(3, 5)) % 4;
        v = 4'b0001 << idx;
      end else if (r < 80) v = 4'b0000;
      else if (r < 88) v = 4'($urandom_range(0, 15));
      else if (r < 94) begin
        idx = (idx + 2) % 4;
        v = 4'b0001 << idx;
      end else v = 4'b0101;
      for (int i = 0; i < $urandom_range(1, 5); i++)
        cycle(v, ($urandom_range(0, 199) != 0), ($urandom_range(0, 9) == 0));
    end
    checks++;
    if (cyc_mismatch != 0) begin
      errors++;
      $display("FAIL cycle_model: got %0d mismatching cycles expected 0", cyc_mismatch);
    end
    checks++;
    if (dut_steps != mdl_steps) begin
      errors++;
      $display("FAIL random_steps: got %0d steps expected %0d", dut_steps, mdl_steps);
    end
  endtask

  initial begin
    rst_n   = 1'b0;
    clr_err = 1'b0;
    {p4, p3, p2, p1} = 4'b0000;
    model_reset();
    clear_stats();
    test_reset();
    test_forward();
    test_reverse();
    test_glitch();
    test_skip_fault();
    test_illegal_gap();
    test_clr_collision();
    test_reset_mid();
    checks++;
    if (cyc_mismatch != 0) begin
      errors++;
      $display("FAIL directed_model: got %0d mismatching cycles expected 0", cyc_mismatch);
    end
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
